mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencing controller for the MAC unit's shared shift-add datapath.
- Accepts unsigned operand pairs over a valid/ready stream and multiplies each pair serially, one multiplier bit per cycle.
- Adds each product into a running accumulator.
- At the pair flagged last, presents the dot-product result on a valid/ready output stream.
- Sits between the operand source (buffer or testbench) and the result consumer.

Parameters:
- DW, 8, operand width (bits) of in_a and in_b; must be ≥2.
- ACCW, 20, accumulator width; must be ≥2*DW.
- CNTW, 8, width of the pair counter out_len.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept a pair.
- in_a  input  DW  multiplicand, unsigned.
- in_b  input  DW  multiplier, unsigned.
- in_last  input  1  pair is final term of current dot product.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_acc  output  ACCW  accumulated dot product.
- out_len  output  CNTW  number of pairs accumulated (wraps mod 2^CNTW).
- out_ovf  output  1  sticky: accumulator exceeded ACCW bits during this dot product.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - State IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - out_acc=0, out_len=0, out_ovf=0.
  - Internal product, bit counter, and latched a/b/last cleared.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a, b, last; clear product; bitcnt=0; go MUL.
  - MUL: in_ready=0. Each cycle, if b[bitcnt]=1 then product += a<<bitcnt (2*DW bits); bitcnt++. After the cycle with bitcnt=DW-1, go ACC. Exactly DW cycles.
  - ACC: {carry,acc} = acc + zero-extended product; out_len++. Set ovf if carry. If last, go DONE, else go IDLE.
  - DONE: out_valid=1; out_acc, out_len, and out_ovf are stable while out_valid=1 and out_ready=0. On out_ready, clear acc, out_len, and ovf; go IDLE.
- Latency and throughput:
  - Handshake in cycle T → ACC in cycle T+DW+1 → out_valid high from T+DW+2.
  - Throughput is one pair per DW+2 cycles.
- in_ready is only high in IDLE. in_valid outside IDLE is ignored; the pair is not consumed.
- out_valid may stay high indefinitely under backpressure; no new pair is accepted until the result drains.
- Wrap-around:
  - Without saturation, acc wraps mod 2^ACCW.
  - out_len wraps mod 2^CNTW; no flag.
- Zero operands still take the full DW cycles, so timing is data-independent.
- Reset mid-operation (any state): immediate return to reset values; any partial product and accumulation are discarded.
- out_acc reflects the live accumulator in all states. Consumers sample it only when out_valid=1.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: on carry in ACC, acc is clamped to 2^ACCW-1, and subsequent adds keep it clamped. out_ovf is still set.
- Undefined: acc wraps mod 2^ACCW; out_ovf flags the wrap.

Decomposition:
- Package mac_pkg:
  - State enum (IDLE, MUL, ACC, DONE).
  - Default DW/ACCW/CNTW constants.
  - Function for the saturation max value.
- Natural sub-module: mac_shift_add_unit, the serial DW-cycle shift-add multiplier datapath. It has start/done strobes and a 2*DW product, and is built from the team's hadd/full-adder cells. mac_seq_ctrl holds the FSM, accumulator, and handshakes.

Test Plan:
1. Single pair a=3, b=5, last=1 (DW=8):
   - in_ready drops the cycle after the handshake.
   - out_valid rises exactly 10 cycles after the handshake, with out_acc=15, out_len=1, out_ovf=0.
2. Three pairs (2,3), (4,5), (6,7), last on the third, out_ready=1:
   - out_acc=68, out_len=3.
   - Pair spacing is 10 cycles.
   - Accumulator reads 0 after the drain.
3. Seventeen pairs (255,255), last on the 17th (expected 1105425):
   - MAC_SAT_EN undefined: out_acc=56849, out_ovf=1.
   - MAC_SAT_EN defined: out_acc=1048575, out_ovf=1.
4. Backpressure: hold out_ready=0 for 6 cycles in DONE with in_valid=1 throughout.
   - out_valid and out_acc stay stable; in_ready=0; no pair consumed.
   - The next pair is accepted only after the out_ready handshake.
5. Reset mid-operation: assert rst_n=0 in the 4th MUL cycle of a (7,9) pair after a prior accumulation of 50.
   - All outputs at reset values immediately, asynchronously.
   - Next dot product (1,1,last) gives out_acc=1, out_len=1.
6. Zero operands (0,255) then (255,0), last:
   - out_acc=0, out_ovf=0.
   - Each pair still takes 10 cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default sizes for the MAC sequencing controller.
// The saturation helper is only referenced when MAC_SAT_EN is defined.
package mac_pkg;

   localparam int DW_DEF   = 8;
   localparam int ACCW_DEF = 20;
   localparam int CNTW_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_ACC  = 2'd2,
      ST_DONE = 2'd3
   } mac_state_e;

   // Largest value an accumulator of the given width can hold (widths up to 63).
   function automatic logic [63:0] sat_max(input int unsigned accw);
      return (64'd1 << accw) - 64'd1;
   endfunction

endpackage

// File: rtl/mac_adder_cells.sv
// Single-bit adder cells used to build the ripple adder inside the shift-add unit.

module hadd (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;
endmodule

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// File: rtl/mac_shift_add_unit.sv
// Serial shift-add multiplier: one multiplier bit per cycle, exactly DW cycles per
// product regardless of operand values. start_i latches operands, done_o marks the last bit.
module mac_shift_add_unit #(
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [DW-1:0]   a_i,
   input  logic [DW-1:0]   b_i,
   output logic            done_o,
   output logic [2*DW-1:0] product_o
);
   localparam int PW = 2 * DW;
   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic [PW-1:0] prod_q;
   logic [PW-1:0] prod_d;
   logic [PW-1:0] addend;
   logic [PW-1:0] carry;
   logic [CW-1:0] cnt_q;
   logic          run_q;
   logic          unused_carry;

   assign addend = b_q[cnt_q] ? (PW'(a_q) << cnt_q) : '0;

   // The product never exceeds 2*DW bits, so the final carry is dropped.
   hadd u_bit0 (
      .a_i (prod_q[0]),
      .b_i (addend[0]),
      .s_o (prod_d[0]),
      .c_o (carry[0])
   );

   for (genvar i = 1; i < PW; i++) begin : g_fa
      full_adder u_fa (
         .a_i  (prod_q[i]),
         .b_i  (addend[i]),
         .ci_i (carry[i-1]),
         .s_o  (prod_d[i]),
         .co_o (carry[i])
      );
   end

   assign unused_carry = carry[PW-1];
   assign done_o       = run_q && (cnt_q == CW'(DW - 1));
   assign product_o    = prod_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         prod_q <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
      end else if (start_i) begin
         a_q    <= a_i;
         b_q    <= b_i;
         prod_q <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b1;
      end else if (run_q) begin
         prod_q <= prod_d;
         cnt_q  <= cnt_q + CW'(1);
         if (done_o) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer around the serial shift-add multiplier: FSM, accumulator and
// valid/ready handshakes. Define MAC_SAT_EN to clamp the accumulator instead of wrapping.
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int ACCW = ACCW_DEF,
   parameter int CNTW = CNTW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_a,
   input  logic [DW-1:0]   in_b,
   input  logic            in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ACCW-1:0] out_acc,
   output logic [CNTW-1:0] out_len,
   output logic            out_ovf,
   output logic            busy
);
   localparam int PW = 2 * DW;

   // Handshake rule on both streams: a transfer happens on a rising clk edge where
   // valid and ready are both high; the producer holds its data stable until then.

   mac_state_e      state_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic            busy_q;
   logic            last_q;
   logic [ACCW-1:0] acc_q;
   logic [ACCW-1:0] acc_d;
   logic [CNTW-1:0] len_q;
   logic            ovf_q;

   logic            start;
   logic            mul_done;
   logic [PW-1:0]   product;
   logic [ACCW:0]   sum_w;

   // in_ready_q is only ever high in IDLE, so it alone qualifies the start.
   assign start = in_valid && in_ready_q;

   mac_shift_add_unit #(
      .DW (DW)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start),
      .a_i       (in_a),
      .b_i       (in_b),
      .done_o    (mul_done),
      .product_o (product)
   );

   assign sum_w = {1'b0, acc_q} + {{(ACCW + 1 - PW){1'b0}}, product};

`ifdef MAC_SAT_EN
   localparam logic [ACCW-1:0] ACC_MAX = ACCW'(sat_max(ACCW));

   // Once clamped, any non-zero add carries again, so the value stays at the max.
   always_comb begin
      acc_d = sum_w[ACCW-1:0];
      if (sum_w[ACCW]) acc_d = ACC_MAX;
   end
`else
   always_comb begin
      acc_d = sum_w[ACCW-1:0];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         last_q      <= 1'b0;
         acc_q       <= '0;
         len_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  last_q     <= in_last;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_MUL;
               end
            end
            ST_MUL: begin
               if (mul_done) state_q <= ST_ACC;
            end
            ST_ACC: begin
               acc_q <= acc_d;
               len_q <= len_q + CNTW'(1);
               if (sum_w[ACCW]) ovf_q <= 1'b1;
               if (last_q) begin
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  acc_q       <= '0;
                  len_q       <= '0;
                  ovf_q       <= 1'b0;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_acc   = acc_q;
   assign out_len   = len_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: directed scenarios plus random dot products, scored against
// a plain-arithmetic dot-product model through expected-result and expected-latency queues.
module tb_mac_seq_ctrl;

   localparam int DW   = 8;
   localparam int ACCW = 20;
   localparam int CNTW = 8;
   localparam int LAT  = DW + 2;
   localparam longint unsigned ACC_LIM = (64'd1 << ACCW);

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_a;
   logic [DW-1:0]   in_b;
   logic            in_last;
   logic            out_valid;
   logic            out_ready;
   logic [ACCW-1:0] out_acc;
   logic [CNTW-1:0] out_len;
   logic            out_ovf;
   logic            busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit rand_ready = 0;

   logic [ACCW+CNTW:0] exp_q[$];
   int                 exp_rise_q[$];
   longint unsigned    model_tot = 0;
   int                 model_cnt = 0;

   mac_seq_ctrl #(
      .DW   (DW),
      .ACCW (ACCW),
      .CNTW (CNTW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_len   (out_len),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_accept(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic last, input int hs);
      logic [ACCW-1:0] ea;
      logic            eo;
      model_tot = model_tot + longint'(a) * longint'(b);
      model_cnt = model_cnt + 1;
      if (last) begin
         eo = (model_tot >= ACC_LIM);
`ifdef MAC_SAT_EN
         ea = eo ? ACCW'(ACC_LIM - 1) : ACCW'(model_tot);
`else
         ea = ACCW'(model_tot % ACC_LIM);
`endif
         exp_q.push_back({ea, CNTW'(model_cnt), eo});
         exp_rise_q.push_back(hs + LAT);
         model_tot = 0;
         model_cnt = 0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last,
                            input bit hold, output int hs);
      bit got;
      got = 0;
      hs  = -1;
      in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            hs  = cyc;
         end
      end
      if (!got) begin
         check("accept_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
      model_accept(a, b, last, hs);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int n = 0; n < 1000 && !ok; n++) begin
         @(negedge clk);
         if (!busy && !out_valid && exp_q.size() == 0) ok = 1;
      end
      if (!ok) check("idle_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  64'(in_ready),  64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_busy"},      64'(busy),      64'd0);
      check({tag, "_out_acc"},   64'(out_acc),   64'd0);
      check({tag, "_out_len"},   64'(out_len),   64'd0);
      check({tag, "_out_ovf"},   64'(out_ovf),   64'd0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic               prev_v = 1'b0;
   logic               prev_r = 1'b0;
   logic [ACCW+CNTW:0] prev_d = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_v = 1'b0;
         prev_r = 1'b0;
      end else begin
         if (out_valid && !prev_v) begin
            if (exp_rise_q.size() == 0) check("rise_unexpected", 64'd1, 64'd0);
            else check("valid_latency", 64'(cyc), 64'(exp_rise_q.pop_front()));
         end
         if (prev_v && !prev_r) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'({out_acc, out_len, out_ovf}), 64'(prev_d));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("result_unexpected", 64'd1, 64'd0);
            else check("result", 64'({out_acc, out_len, out_ovf}), 64'(exp_q.pop_front()));
         end
         prev_v = out_valid;
         prev_r = out_ready;
         prev_d = {out_acc, out_len, out_ovf};
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int h, h1, h2, h3, c, len;
      bit seen;
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single pair: in_ready drops right after the handshake
      send_pair(8'd3, 8'd5, 1'b1, 1'b0, h);
      @(negedge clk);
      check("ready_drop", 64'(in_ready), 64'd0);
      wait_idle();

      // three pairs back to back, fixed spacing, accumulator cleared after drain
      send_pair(8'd2, 8'd3, 1'b0, 1'b1, h1);
      send_pair(8'd4, 8'd5, 1'b0, 1'b1, h2);
      send_pair(8'd6, 8'd7, 1'b1, 1'b0, h3);
      check("spacing_12", 64'(h2 - h1), 64'(LAT));
      check("spacing_23", 64'(h3 - h2), 64'(LAT));
      wait_idle();
      check("drain_acc", 64'(out_acc), 64'd0);
      check("drain_len", 64'(out_len), 64'd0);

      // seventeen full-scale pairs overflow the accumulator
      for (int i = 0; i < 17; i++) send_pair(8'd255, 8'd255, 1'(i == 16), 1'(i != 16), h);
      wait_idle();

      // backpressure with a pair waiting
      out_ready = 1'b0;
      send_pair(8'd2, 8'd2, 1'b1, 1'b0, h);
      in_a = 8'd3; in_b = 8'd3; in_last = 1'b1; in_valid = 1'b1;
      seen = 0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      if (!seen) check("bp_valid_timeout", 64'd0, 64'd1);
      repeat (6) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_busy", 64'(busy), 64'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      c = cyc;
      send_pair(8'd3, 8'd3, 1'b1, 1'b0, h);
      check("bp_accept_after_drain", 64'(h), 64'(c + 1));
      wait_idle();

      // asynchronous reset in the 4th multiply cycle after accumulating 50
      send_pair(8'd5, 8'd10, 1'b0, 1'b0, h);
      send_pair(8'd7, 8'd9, 1'b1, 1'b0, h);
      while (cyc < h + 4) @(negedge clk);
      check("pre_reset_acc", 64'(out_acc), 64'd50);
      check("pre_reset_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      exp_q.delete();
      exp_rise_q.delete();
      model_tot = 0;
      model_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_pair(8'd1, 8'd1, 1'b1, 1'b0, h);
      wait_idle();

      // zero operands still take the full multiply time
      send_pair(8'd0, 8'd255, 1'b0, 1'b1, h1);
      send_pair(8'd255, 8'd0, 1'b1, 1'b0, h2);
      check("zero_spacing", 64'(h2 - h1), 64'(LAT));
      wait_idle();

      // random dot products with random consumer stalls
      rand_ready = 1;
      for (int d = 0; d < 25; d++) begin
         len = $urandom_range(1, 5);
         for (int p = 0; p < len; p++) begin
            send_pair(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)),
                      1'(p == len - 1), 1'($urandom_range(0, 1)), h);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
      end
      rand_ready = 0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      wait_idle();

      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      check("exp_rise_q_empty", 64'(exp_rise_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
